// File: rtl/sm_pkg.sv
// Shared types and signed-magnitude helpers for the MLP datapath.
// Helpers take the word width as an argument so every stage can reuse them.
package sm_pkg;

  localparam int SM_MAXW = 64;

  typedef logic [SM_MAXW-1:0] sm_word_t;

  localparam sm_word_t SM_POS_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  function automatic sm_word_t sm_mag(
    input sm_word_t x,
    input int       w
  );
    return x & (~SM_POS_ZERO >> (SM_MAXW - w + 1));
  endfunction

  // -0 is reported as non-negative
  function automatic logic sm_is_neg(
    input sm_word_t x,
    input int       w
  );
    return x[w-1] && (sm_mag(x, w) != SM_POS_ZERO);
  endfunction

  function automatic sm_word_t sm_max_mag(
    input logic s,
    input int   w
  );
    return sm_mag(~SM_POS_ZERO, w) | (sm_word_t'(s) << (w - 1));
  endfunction

endpackage

// File: rtl/sm_add_sat.sv
// Combinational saturating signed-magnitude adder.
// Never produces -0; flags magnitude overflow.
module sm_add_sat
  import sm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int M = WIDTH - 1;

  logic         w_sa;
  logic         w_sb;
  logic [M-1:0] w_ma;
  logic [M-1:0] w_mb;
  logic [M:0]   w_add;

  assign w_sa  = sm_is_neg(sm_word_t'(a), WIDTH);
  assign w_sb  = sm_is_neg(sm_word_t'(b), WIDTH);
  assign w_ma  = a[M-1:0];
  assign w_mb  = b[M-1:0];
  assign w_add = {1'b0, w_ma} + {1'b0, w_mb};

  always_comb begin
    sum      = '0;
    overflow = 1'b0;
    if (w_sa == w_sb) begin
      if (w_add[M]) begin
        sum      = {w_sa, {M{1'b1}}};
        overflow = 1'b1;
      end else begin
        sum = {w_sa & (w_add[M-1:0] != '0), w_add[M-1:0]};
      end
    end else if (w_ma > w_mb) begin
      sum = {w_sa, w_ma - w_mb};
    end else if (w_mb > w_ma) begin
      sum = {w_sb, w_mb - w_ma};
    end
  end

endmodule

// File: rtl/sm_accumulator.sv
// Handshaked packet accumulator: sums signed-magnitude beats
// until in_last, then holds the saturated result for downstream.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 17,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  if (FRAC_BITS >= WIDTH - 1) begin : g_bad_frac
    $error("FRAC_BITS must leave at least one integer bit");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_sat;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_out_count;

  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_beat;
  logic             w_take;

  sm_add_sat #(
    .WIDTH(WIDTH)
  ) u_add (
    .a       (r_acc),
    .b       (in_data),
    .sum     (w_sum),
    .overflow(w_ovf)
  );

  // rst_n gates in_ready so nothing is offered while reset is held
  assign in_ready  = rst_n && (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_count = r_out_count;

  assign w_beat    = in_valid && in_ready;
  assign w_take    = out_valid && out_ready;
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_count <= '0;
    end else if (w_take) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_beat) begin
      r_acc <= w_sum;
      r_sat <= r_sat | w_ovf;
      r_cnt <= w_cnt_nxt;
      if (in_last) begin
        r_state     <= HOLD;
        r_out_data  <= w_sum;
        r_out_sat   <= r_sat | w_ovf;
        r_out_count <= w_cnt_nxt;
      end else begin
        r_state <= ACC;
      end
    end
  end

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator with hand-computed sums.
module tb_sm_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sat;
  logic [7:0]  out_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sm_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_count(out_count)
  );

  // called at a negedge; returns at the negedge after acceptance
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_ready got %b required 0", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out_valid got %b required 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 32'h0 || out_sat !== 1'b0 || out_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_outputs got %h/%b/%0d required 0/0/0",
               out_data, out_sat, out_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release got ready=%b valid=%b required 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_pi_e();
    out_ready = 1'b1;
    send_beat(32'h0006487E, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pie_early_valid got %b required 0", out_valid);
    end
    send_beat(32'h00056FC2, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pie_valid got %b required 1", out_valid);
    end
    n_cmp++;
    if (out_data !== 32'h000BB840 || out_sat !== 1'b0 || out_count !== 8'd2) begin
      n_fail++;
      $display("FAIL pie_result got %h/%b/%0d required 000bb840/0/2",
               out_data, out_sat, out_count);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pie_consume got valid=%b ready=%b required 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_arith();
    logic [31:0] pk [6][3];
    int          len [6];
    logic [31:0] ed [6];
    logic        es [6];
    logic [7:0]  ec [6];
    pk  = '{'{32'h0006487E, 32'h80056FC2, 32'h0},
            '{32'h00056FC2, 32'h8006487E, 32'h0},
            '{32'h0006487E, 32'h8006487E, 32'h0},
            '{32'h80000000, 32'h0, 32'h0},
            '{32'h7FFFFFFF, 32'h00000001, 32'h80000005},
            '{32'hFFFFFFFF, 32'h80000002, 32'h0}};
    len = '{2, 2, 2, 1, 3, 2};
    ed  = '{32'h0000D8BC, 32'h8000D8BC, 32'h0, 32'h0,
            32'h7FFFFFFA, 32'hFFFFFFFF};
    es  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ec  = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd3, 8'd2};
    out_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < len[p]; k++)
        send_beat(pk[p][k], k == len[p] - 1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== ed[p] ||
          out_sat !== es[p] || out_count !== ec[p]) begin
        n_fail++;
        $display("FAIL arith_pkt%0d got v=%b %h/%b/%0d required 1 %h/%b/%0d",
                 p, out_valid, out_data, out_sat, out_count,
                 ed[p], es[p], ec[p]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(32'h0006487E, 1'b0);
    send_beat(32'h00056FC2, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h00001000;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== 32'h000BB840 || out_count !== 8'd2) begin
        n_fail++;
        $display("FAIL bp_hold%0d got r=%b v=%b %h/%0d required 0 1 000bb840/2",
                 c, in_ready, out_valid, out_data, out_count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got ready=%b valid=%b required 1/0",
               in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h00001000 ||
        out_sat !== 1'b0 || out_count !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_second got v=%b %h/%b/%0d required 1 00001000/0/1",
               out_valid, out_data, out_sat, out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_beat(32'h00000100, 1'b0);
    send_beat(32'h00000200, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async got ready=%b valid=%b required 0/0",
               in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(32'h00020000, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h00020000 ||
        out_sat !== 1'b0 || out_count !== 8'd1) begin
      n_fail++;
      $display("FAIL midrst_result got v=%b %h/%b/%0d required 1 00020000/0/1",
               out_valid, out_data, out_sat, out_count);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pi_e();
    test_arith();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
